// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the data-memory interface.
//   Used by both the store/enable side and the load-return path.
//   mem_op_e   : memOp field values
//   mem_size_e : memSize field values
//   load_tag_t : per-load bookkeeping carried through the read-latency pipeline
package mem_pkg;

   typedef enum logic [1:0] {
      MEM_NONE     = 2'b00,
      MEM_LOAD     = 2'b01,
      MEM_LOAD_ROM = 2'b10,
      MEM_STORE    = 2'b11
   } mem_op_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } mem_size_e;

   typedef struct packed {
      logic [1:0] offset;   // addr[1:0]
      mem_size_e  size;
      logic       sgn;      // 1 = sign-extend
      logic       rom;      // 1 = data returns on romDout
   } load_tag_t;

   function automatic logic is_load(input logic [1:0] op);
      return (op == MEM_LOAD) || (op == MEM_LOAD_ROM);
   endfunction

endpackage

// File: rtl/mem_output_logic_if.sv
// mem_output_logic_if: request, memory-return and writeback signals of the
// load-return path.
//   master : issue stage + memories + writeback (drives requests, read data, wb_ready)
//   slave  : mem_output_logic (drives req_ready, resp_valid, dout, err)
interface mem_output_logic_if;

   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic [1:0]  memOp;
   logic [1:0]  memSize;
   logic        memSigned;
   logic [31:0] ramDout;
   logic [31:0] romDout;
   logic        resp_valid;
   logic        wb_ready;
   logic [31:0] dout;
   logic        err;

   modport master (
      output req_valid, addr, memOp, memSize, memSigned, ramDout, romDout, wb_ready,
      input  req_ready, resp_valid, dout, err
   );

   modport slave (
      input  req_valid, addr, memOp, memSize, memSigned, ramDout, romDout, wb_ready,
      output req_ready, resp_valid, dout, err
   );

endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load extraction.
//   word   in  32  raw memory word
//   offset in  2   byte offset addr[1:0]
//   size   in  2   byte / half / word / reserved
//   sgn    in  1   sign-extend when set
//   dout   out 32  aligned, extended data (0 when err)
//   err    out 1   misaligned access or reserved size
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  mem_size_e   size,
   input  logic        sgn,
   output logic [31:0] dout,
   output logic        err
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{offset, 3'b000} +: 8];
      half_sel = word[{offset[1], 4'b0000} +: 16];
      dout     = '0;
      err      = 1'b0;
      case (size)
         SZ_BYTE: dout = sgn ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
         SZ_HALF: begin
            if (offset[0]) err  = 1'b1;
            else           dout = sgn ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
         end
         SZ_WORD: begin
            if (offset != 2'b00) err  = 1'b1;
            else                 dout = word;
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_output_logic.sv
// mem_output_logic: load-return path of the data-memory interface.
//   Tracks accepted loads through the RAM/ROM read latency, selects the
//   returning source, aligns/extends the data and buffers results in a FIFO
//   delivered over a valid/ready handshake. req_ready is a credit check so the
//   FIFO can never overflow.
//   clk  in  clock (rising edge)
//   rst  in  synchronous active-high reset
//   bus  slave modport of mem_output_logic_if (request, memory data, response)
module mem_output_logic
   import mem_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned ROM_SEL_BIT  = 28,
   parameter int unsigned FIFO_DEPTH   = READ_LATENCY + 1
) (
   input logic              clk,
   input logic              rst,
   mem_output_logic_if.slave bus
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned IFL_W = $clog2(READ_LATENCY + 1);

   logic                    accept;
   load_tag_t               req_tag;
   logic                    valid_pipe [READ_LATENCY];
   load_tag_t               tag_pipe   [READ_LATENCY];
   logic [READ_LATENCY-1:0] valid_vec;
   logic [IFL_W-1:0]        in_flight;
   logic [CNT_W:0]          used_slots;

   logic                    last_valid;
   load_tag_t               last_tag;
   logic [31:0]             mem_word;
   logic [31:0]             align_dout;
   logic                    align_err;

   logic [32:0]             fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        count;
   logic                    push;
   logic                    pop;
   logic                    head_valid;
   logic [32:0]             head;
   logic                    unused_addr;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Request side
   assign accept = bus.req_valid & bus.req_ready & is_load(bus.memOp);

   // The MEM_LOAD_ROM qualifier in the original decode reduces to the address
   // bit alone: both arms of its select yield addr[ROM_SEL_BIT].
   always_comb begin
      req_tag.offset = bus.addr[1:0];
      req_tag.size   = mem_size_e'(bus.memSize);
      req_tag.sgn    = bus.memSigned;
      req_tag.rom    = bus.addr[ROM_SEL_BIT];
   end

   assign unused_addr = ^bus.addr;

   // Read-latency pipeline: only the valid bits are reset, so data returning
   // for a load issued before reset is never pushed.
   for (genvar s = 0; s < READ_LATENCY; s++) begin : g_stage
      if (s == 0) begin : g_first
         always_ff @(posedge clk) begin
            if (rst) valid_pipe[0] <= 1'b0;
            else     valid_pipe[0] <= accept;
            tag_pipe[0] <= req_tag;
         end
      end else begin : g_next
         always_ff @(posedge clk) begin
            if (rst) valid_pipe[s] <= 1'b0;
            else     valid_pipe[s] <= valid_pipe[s-1];
            tag_pipe[s] <= tag_pipe[s-1];
         end
      end
      assign valid_vec[s] = valid_pipe[s];
   end

   assign in_flight = IFL_W'($countones(valid_vec));

   // Return side
   assign last_valid = valid_pipe[READ_LATENCY-1];
   assign last_tag   = tag_pipe[READ_LATENCY-1];
   assign mem_word   = last_tag.rom ? bus.romDout : bus.ramDout;

   mem_load_align u_align (
      .word   (mem_word),
      .offset (last_tag.offset),
      .size   (last_tag.size),
      .sgn    (last_tag.sgn),
      .dout   (align_dout),
      .err    (align_err)
   );

   // Result FIFO
   assign head_valid = (count != '0);
   assign push       = last_valid;
   assign pop        = head_valid & bus.wb_ready;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {align_err, align_dout};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head           = fifo_mem[rd_ptr];
   assign bus.resp_valid = head_valid;
   assign bus.dout       = head_valid ? head[31:0] : '0;
   assign bus.err        = head_valid & head[32];

   // Credit: buffered results plus loads still in the pipeline must leave a
   // free slot; registered state only, so no path from req_valid.
   assign used_slots    = {1'b0, count} + (CNT_W + 1)'(in_flight);
   assign bus.req_ready = (used_slots < (CNT_W + 1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_mem_output_logic.sv
module tb_mem_output_logic;
   import mem_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   logic [31:0] ram [16];
   logic [31:0] rom [16];

   mem_output_logic_if bus ();

   mem_output_logic #(
      .READ_LATENCY (1),
      .ROM_SEL_BIT  (28),
      .FIFO_DEPTH   (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Synchronous memories, always enabled: data for the address presented in
   // cycle N appears in cycle N+1.
   always @(posedge clk) begin
      bus.ramDout <= ram[bus.addr[5:2]];
      bus.romDout <= rom[bus.addr[5:2]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [1:0] op,
                        input logic [1:0] sz, input logic sg);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.addr      = a;
      bus.memOp     = op;
      bus.memSize   = sz;
      bus.memSigned = sg;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.memOp     = MEM_NONE;
   endtask

   // Single load with wb_ready high: nothing one cycle after accept, result the next.
   task automatic load_check(input string tag, input logic [31:0] a, input logic [1:0] op,
                             input logic [1:0] sz, input logic sg,
                             input logic [31:0] exp_d, input logic exp_e);
      issue(a, op, sz, sg);
      check({tag, "_early"}, {31'b0, bus.resp_valid}, 32'd0);
      @(negedge clk);
      check({tag, "_valid"}, {31'b0, bus.resp_valid}, 32'd1);
      check({tag, "_dout"}, bus.dout, exp_d);
      check({tag, "_err"}, {31'b0, bus.err}, {31'b0, exp_e});
   endtask

   initial begin
      logic [31:0] exp_b [4];
      exp_b[0] = 32'h0000_00EF;
      exp_b[1] = 32'h0000_00BE;
      exp_b[2] = 32'h0000_00AD;
      exp_b[3] = 32'h0000_00DE;

      for (int i = 0; i < 16; i++) begin
         ram[i] = 32'h0;
         rom[i] = 32'h0;
      end
      ram[0] = 32'h8000_0000;
      ram[1] = 32'hDEAD_BEEF;
      rom[4] = 32'h1234_5678;

      bus.req_valid = 1'b0;
      bus.addr      = 32'h0;
      bus.memOp     = MEM_NONE;
      bus.memSize   = SZ_WORD;
      bus.memSigned = 1'b0;
      bus.wb_ready  = 1'b1;

      // Reset
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
      check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      check("rst_dout", bus.dout, 32'd0);
      check("rst_err", {31'b0, bus.err}, 32'd0);

      // Directed single loads
      load_check("ram_word",   32'h0000_0004, MEM_LOAD,     SZ_WORD, 1'b0, 32'hDEAD_BEEF, 1'b0);
      load_check("byte_s",     32'h0000_0003, MEM_LOAD,     SZ_BYTE, 1'b1, 32'hFFFF_FF80, 1'b0);
      load_check("byte_u",     32'h0000_0003, MEM_LOAD,     SZ_BYTE, 1'b0, 32'h0000_0080, 1'b0);
      load_check("rom_half",   32'h1000_0012, MEM_LOAD_ROM, SZ_HALF, 1'b0, 32'h0000_1234, 1'b0);
      load_check("half_s",     32'h0000_0006, MEM_LOAD,     SZ_HALF, 1'b1, 32'hFFFF_DEAD, 1'b0);
      load_check("byte_u5",    32'h0000_0005, MEM_LOAD,     SZ_BYTE, 1'b0, 32'h0000_00BE, 1'b0);
      load_check("mis_half",   32'h0000_0001, MEM_LOAD,     SZ_HALF, 1'b1, 32'h0,         1'b1);
      load_check("mis_word",   32'h0000_0002, MEM_LOAD,     SZ_WORD, 1'b0, 32'h0,         1'b1);
      load_check("rsvd_size",  32'h0000_0004, MEM_LOAD,     SZ_RSVD, 1'b0, 32'h0,         1'b1);

      // Store produces no response
      issue(32'h0000_0004, MEM_STORE, SZ_WORD, 1'b0);
      check("store_none0", {31'b0, bus.resp_valid}, 32'd0);
      @(negedge clk);
      check("store_none1", {31'b0, bus.resp_valid}, 32'd0);

      // Back-to-back byte loads, one result per cycle
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k < 4) begin
            check("b2b_ready", {31'b0, bus.req_ready}, 32'd1);
            bus.req_valid = 1'b1;
            bus.addr      = 32'h4 + k;
            bus.memOp     = MEM_LOAD;
            bus.memSize   = SZ_BYTE;
            bus.memSigned = 1'b0;
         end else begin
            bus.req_valid = 1'b0;
            bus.memOp     = MEM_NONE;
         end
         if (k >= 2) begin
            check("b2b_valid", {31'b0, bus.resp_valid}, 32'd1);
            check("b2b_dout", bus.dout, exp_b[k-2]);
         end
      end
      @(negedge clk);
      check("b2b_empty", {31'b0, bus.resp_valid}, 32'd0);

      // Backpressure: wb_ready low for 10 cycles while loads are offered
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         bus.wb_ready = 1'b0;
         check("bp_ready", {31'b0, bus.req_ready}, (k < 3) ? 32'd1 : 32'd0);
         bus.req_valid = 1'b1;
         bus.addr      = 32'h4 + k;
         bus.memOp     = MEM_LOAD;
         bus.memSize   = SZ_BYTE;
         bus.memSigned = 1'b0;
         if (k == 9) check("bp_hold_dout", bus.dout, 32'h0000_00EF);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.memOp     = MEM_NONE;
      check("bp_drain0_valid", {31'b0, bus.resp_valid}, 32'd1);
      check("bp_drain0", bus.dout, 32'h0000_00EF);
      bus.wb_ready = 1'b1;
      @(negedge clk);
      check("bp_drain1", bus.dout, 32'h0000_00BE);
      @(negedge clk);
      check("bp_drain2", bus.dout, 32'h0000_00AD);
      @(negedge clk);
      check("bp_empty", {31'b0, bus.resp_valid}, 32'd0);
      check("bp_ready_back", {31'b0, bus.req_ready}, 32'd1);

      // Reset one cycle after an accept discards the load
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.addr      = 32'h0000_0004;
      bus.memOp     = MEM_LOAD;
      bus.memSize   = SZ_WORD;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.memOp     = MEM_NONE;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rstmid_no_resp", {31'b0, bus.resp_valid}, 32'd0);
      end
      check("rstmid_ready", {31'b0, bus.req_ready}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
